// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB hue-wheel controller.
package rgb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef logic [2:0] phase_t;

    localparam int NUM_HUE_PHASES = 6;

    // Advance around the hue wheel, wrapping after the last phase.
    function automatic phase_t next_phase(input phase_t p);
        if (p == phase_t'(NUM_HUE_PHASES - 1)) begin
            return phase_t'(0);
        end
        return phase_t'(p + phase_t'(1));
    endfunction

endpackage

// File: rtl/rgb_phase_controller_if.sv
// Override channel for the RGB hue-wheel controller.
//
// Handshake: a transfer happens on a rising clk edge where ovr_valid and
// ovr_ready are both 1. ovr_ready depends only on controller state, never on
// ovr_valid. The master holds ovr_r/g/b stable while ovr_valid is 1.
// ovr_release is a one-cycle pulse outside the valid/ready handshake that
// ends an active override.
interface rgb_phase_controller_if #(
    parameter int DW = 11
);
    logic          ovr_valid;
    logic          ovr_ready;
    logic [DW-1:0] ovr_r;
    logic [DW-1:0] ovr_g;
    logic [DW-1:0] ovr_b;
    logic          ovr_release;

    modport master (
        output ovr_valid, ovr_r, ovr_g, ovr_b, ovr_release,
        input  ovr_ready
    );

    modport slave (
        input  ovr_valid, ovr_r, ovr_g, ovr_b, ovr_release,
        output ovr_ready
    );
endinterface

// File: rtl/rgb_phase_controller_pwm_gen.sv
// Three-channel PWM engine: period counter, end-of-period strobe, shadow duty
// registers and registered compare outputs.
module pwm_gen #(
    parameter int PWM_INTERVAL = 1800,
    parameter int DW           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic [DW-1:0] d_r,
    input  logic [DW-1:0] d_g,
    input  logic [DW-1:0] d_b,
    output logic          red,
    output logic          green,
    output logic          blue,
    output logic          period_stb
);
    localparam logic [DW-1:0] LAST = DW'(PWM_INTERVAL - 1);

    logic [DW-1:0] cnt;
    logic [DW-1:0] sh_r;
    logic [DW-1:0] sh_g;
    logic [DW-1:0] sh_b;

    // Last cycle of a period; gated so it never fires while parked.
    assign period_stb = en && (cnt == LAST);

    // Period counter: wraps while enabled, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

    // Shadow duties change only when the controller asks, so a period never
    // sees a duty change part-way through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r <= '0;
            sh_g <= '0;
            sh_b <= '0;
        end else if (load) begin
            sh_r <= d_r;
            sh_g <= d_g;
            sh_b <= d_b;
        end
    end

    // Compare stage: duty 0 never goes high, duty PWM_INTERVAL never goes low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else begin
            red   <= en && (cnt < sh_r);
            green <= en && (cnt < sh_g);
            blue  <= en && (cnt < sh_b);
        end
    end

endmodule

// File: rtl/rgb_phase_controller.sv
// RGB hue-wheel controller: run/hold FSM, ramp and phase sequencing, hue table
// and override capture feeding a three-channel PWM engine.
module rgb_phase_controller
    import rgb_pkg::*;
#(
    parameter int PWM_INTERVAL = 1800,
    parameter int MAX_PHASES   = 6,
    parameter int DUTY_STEP    = 60
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    rgb_phase_controller_if.slave  ovr,
    output logic                   red,
    output logic                   green,
    output logic                   blue,
    output phase_t                 phase,
    output logic                   period_stb,
    output state_t                 state
);
    localparam int              DW   = $clog2(PWM_INTERVAL + 1);
    localparam logic [DW-1:0]   MAX  = DW'(PWM_INTERVAL);
    localparam logic [DW:0]     STEP = (DW + 1)'(DUTY_STEP);

    if (MAX_PHASES != NUM_HUE_PHASES) begin : g_bad_phases
        $error("MAX_PHASES must be %0d", NUM_HUE_PHASES);
    end
    if ((DUTY_STEP < 1) || (DUTY_STEP > PWM_INTERVAL)) begin : g_bad_step
        $error("DUTY_STEP must lie in 1..PWM_INTERVAL");
    end

    logic          accept;
    logic          en;
    logic          load;
    logic [DW-1:0] ramp;
    logic [DW-1:0] ramp_nxt;
    phase_t        phase_nxt;
    logic [DW:0]   step_sum;
    logic [DW-1:0] hue_r, hue_g, hue_b;
    logic [DW-1:0] cap_r, cap_g, cap_b;
    logic [DW-1:0] duty_r, duty_g, duty_b;

    function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] v);
        return (v > MAX) ? MAX : v;
    endfunction

    assign ovr.ovr_ready = (state != HOLD);
    assign accept        = ovr.ovr_valid && ovr.ovr_ready;
    assign en            = (state != IDLE);

    // Ramp/phase step taken at the end of every running period.
    always_comb begin
        ramp_nxt  = ramp;
        phase_nxt = phase;
        step_sum  = {1'b0, ramp} + STEP;
        if ((state == RUN) && period_stb) begin
            if (ramp == MAX) begin
                ramp_nxt  = '0;
                phase_nxt = next_phase(phase);
            end else if (step_sum > {1'b0, MAX}) begin
                ramp_nxt = MAX;
            end else begin
                ramp_nxt = step_sum[DW-1:0];
            end
        end
    end

    // Hue table, looked up with the post-step ramp/phase so the shadow load at
    // a period boundary shows the colour of the period that is starting.
    always_comb begin
        hue_r = '0;
        hue_g = '0;
        hue_b = '0;
        case (phase_nxt)
            3'd0: begin hue_r = MAX;            hue_g = ramp_nxt;       end
            3'd1: begin hue_r = MAX - ramp_nxt; hue_g = MAX;            end
            3'd2: begin hue_g = MAX;            hue_b = ramp_nxt;       end
            3'd3: begin hue_g = MAX - ramp_nxt; hue_b = MAX;            end
            3'd4: begin hue_r = ramp_nxt;       hue_b = MAX;            end
            3'd5: begin hue_r = MAX;            hue_b = MAX - ramp_nxt; end
            default: ;
        endcase
    end

    // Duty source and load timing: every period boundary while active, plus
    // the IDLE->RUN edge so the first period already has its colour.
    always_comb begin
        duty_r = (state == HOLD) ? cap_r : hue_r;
        duty_g = (state == HOLD) ? cap_g : hue_g;
        duty_b = (state == HOLD) ? cap_b : hue_b;
        load   = (en && period_stb) || ((state == IDLE) && run && !accept);
    end

    // Controller FSM with ramp/phase registers and override capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ramp  <= '0;
            phase <= '0;
            cap_r <= '0;
            cap_g <= '0;
            cap_b <= '0;
        end else begin
            ramp  <= ramp_nxt;
            phase <= phase_nxt;
            if (accept) begin
                cap_r <= clamp_duty(ovr.ovr_r);
                cap_g <= clamp_duty(ovr.ovr_g);
                cap_b <= clamp_duty(ovr.ovr_b);
            end
            case (state)
                IDLE: begin
                    if (accept)   state <= HOLD;
                    else if (run) state <= RUN;
                end
                RUN: begin
                    if (accept)    state <= HOLD;
                    else if (!run) state <= IDLE;
                end
                HOLD: begin
                    if (ovr.ovr_release) state <= run ? RUN : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    pwm_gen #(
        .PWM_INTERVAL (PWM_INTERVAL),
        .DW           (DW)
    ) u_pwm_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .d_r        (duty_r),
        .d_g        (duty_g),
        .d_b        (duty_b),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .period_stb (period_stb)
    );

endmodule

// File: tb/tb_rgb_phase_controller.sv
// Bench for rgb_phase_controller with a 10-cycle PWM period and a ramp step of 5.
module tb_rgb_phase_controller;
    import rgb_pkg::*;

    localparam int PI       = 10;
    localparam int STEP     = 5;
    localparam int MAXD     = PI;
    localparam int DW       = 4;
    localparam int PPP      = (MAXD + STEP - 1) / STEP + 1;
    localparam int WHEEL    = 6 * PPP;
    localparam int W        = 15;
    localparam int A_NONE    = 0;
    localparam int A_ACCEPT  = 1;
    localparam int A_RELEASE = 2;

    typedef struct { int ph; int r; int g; int b; } hue_vec_t;
    typedef struct { int in_r; int in_g; int in_b; int ex_r; int ex_g; int ex_b; } ovr_vec_t;

    logic   clk;
    logic   rst_n;
    logic   run;
    logic   red, green, blue, period_stb;
    phase_t phase;
    state_t state;

    rgb_phase_controller_if #(.DW(DW)) ovr_if ();

    rgb_phase_controller #(
        .PWM_INTERVAL (PI),
        .MAX_PHASES   (6),
        .DUTY_STEP    (STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ovr        (ovr_if),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .phase      (phase),
        .period_stb (period_stb),
        .state      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] meas_q[$];
    int eph_q[$];
    int ph_q[$];
    int m_k;
    bit m_hold;
    logic [W-1:0] m_ovr;
    bit mon_clear = 1'b1;

    // Per-period high counts; a period closes one cycle after its strobe
    // because the outputs are registered.
    int ar, ag, ab;
    bit stb_d;
    always @(negedge clk) begin
        if (mon_clear) begin
            ar = 0; ag = 0; ab = 0; stb_d = 1'b0;
        end else begin
            ar = ar + int'(red);
            ag = ag + int'(green);
            ab = ab + int'(blue);
            if (stb_d) begin
                meas_q.push_back({ar[4:0], ag[4:0], ab[4:0]});
                ar = 0; ag = 0; ab = 0;
            end
            stb_d = period_stb;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] pack3(input int r, input int g, input int b);
        return {5'(r), 5'(g), 5'(b)};
    endfunction

    function automatic int clampv(input int v);
        return (v > MAXD) ? MAXD : v;
    endfunction

    function automatic int phase_of(input int k);
        return (k % WHEEL) / PPP;
    endfunction

    // Colour of the k-th running period counted from reset.
    function automatic logic [W-1:0] hue_of(input int k);
        int pos, p, rr;
        pos = k % WHEEL;
        p   = pos / PPP;
        rr  = (pos % PPP) * STEP;
        if (rr > MAXD) rr = MAXD;
        case (p)
            0:       return pack3(MAXD, rr, 0);
            1:       return pack3(MAXD - rr, MAXD, 0);
            2:       return pack3(0, MAXD, rr);
            3:       return pack3(0, MAXD - rr, MAXD);
            4:       return pack3(rr, 0, MAXD);
            default: return pack3(MAXD, 0, MAXD - rr);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic clear_queues();
        exp_q.delete(); meas_q.delete(); eph_q.delete(); ph_q.delete();
    endtask

    task automatic check_queues(input string nm);
        chk({nm, "_periods"}, meas_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < meas_q.size(); i++)
            chk($sformatf("%s_duty[%0d]", nm, i), int'(meas_q[i]), int'(exp_q[i]));
        chk({nm, "_phases"}, ph_q.size(), eph_q.size());
        for (int i = 0; i < eph_q.size() && i < ph_q.size(); i++)
            chk($sformatf("%s_phase[%0d]", nm, i), ph_q[i], eph_q[i]);
        clear_queues();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        ovr_if.ovr_valid = 1'b0; ovr_if.ovr_release = 1'b0;
        ovr_if.ovr_r = '0; ovr_if.ovr_g = '0; ovr_if.ovr_b = '0;
        mon_clear = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        m_k = 0; m_hold = 1'b0; m_ovr = '0;
        clear_queues();
    endtask

    // From IDLE: raise run; returns at the first cycle of the first period.
    task automatic start_run();
        mon_clear = 1'b1;
        run = 1'b1;
        exp_q.push_back(hue_of(m_k));
        cyc(1);
        mon_clear = 1'b0;
    endtask

    // Runs one full period starting on its first cycle, with an optional
    // mid-period override action.
    task automatic do_period(input int action, input int vr, input int vg, input int vb);
        cyc(4);
        if (action == A_ACCEPT) begin
            ovr_if.ovr_valid = 1'b1;
            ovr_if.ovr_r = 4'(vr); ovr_if.ovr_g = 4'(vg); ovr_if.ovr_b = 4'(vb);
            cyc(1);
            ovr_if.ovr_valid = 1'b0;
            if (!m_hold) begin
                m_hold = 1'b1;
                m_ovr  = pack3(clampv(vr), clampv(vg), clampv(vb));
            end
        end else if (action == A_RELEASE) begin
            ovr_if.ovr_release = 1'b1;
            cyc(1);
            ovr_if.ovr_release = 1'b0;
            m_hold = 1'b0;
        end else begin
            cyc(1);
        end
        chk("ovr_ready", int'(ovr_if.ovr_ready), int'(!m_hold));
        cyc(4);
        chk("period_stb", int'(period_stb), 1);
        ph_q.push_back(int'(phase));
        eph_q.push_back(phase_of(m_k));
        if (m_hold) begin
            exp_q.push_back(m_ovr);
        end else begin
            m_k++;
            exp_q.push_back(hue_of(m_k));
        end
        cyc(1);
    endtask

    // Final period: drop run on its strobe cycle and let it be measured.
    task automatic end_run();
        cyc(9);
        chk("period_stb_last", int'(period_stb), 1);
        ph_q.push_back(int'(phase));
        eph_q.push_back(phase_of(m_k));
        run = 1'b0;
        if (!m_hold) m_k++;
        cyc(3);
        chk("idle_after_stop", int'(state), int'(IDLE));
    endtask

    // ---------------- test sequence ----------------
    hue_vec_t hue_tab[WHEEL];
    ovr_vec_t ovr_tab[4];

    initial begin
        hue_tab[0]  = '{0, 10, 0, 0};   hue_tab[1]  = '{0, 10, 5, 0};   hue_tab[2]  = '{0, 10, 10, 0};
        hue_tab[3]  = '{1, 10, 10, 0};  hue_tab[4]  = '{1, 5, 10, 0};   hue_tab[5]  = '{1, 0, 10, 0};
        hue_tab[6]  = '{2, 0, 10, 0};   hue_tab[7]  = '{2, 0, 10, 5};   hue_tab[8]  = '{2, 0, 10, 10};
        hue_tab[9]  = '{3, 0, 10, 10};  hue_tab[10] = '{3, 0, 5, 10};   hue_tab[11] = '{3, 0, 0, 10};
        hue_tab[12] = '{4, 0, 0, 10};   hue_tab[13] = '{4, 5, 0, 10};   hue_tab[14] = '{4, 10, 0, 10};
        hue_tab[15] = '{5, 10, 0, 10};  hue_tab[16] = '{5, 10, 0, 5};   hue_tab[17] = '{5, 10, 0, 0};
        ovr_tab[0] = '{3, 12, 0, 3, 10, 0};
        ovr_tab[1] = '{15, 10, 7, 10, 10, 7};
        ovr_tab[2] = '{0, 0, 0, 0, 0, 0};
        ovr_tab[3] = '{11, 1, 10, 10, 1, 10};

        // T1: values held in reset
        rst_n = 1'b0; run = 1'b0;
        ovr_if.ovr_valid = 1'b0; ovr_if.ovr_release = 1'b0;
        ovr_if.ovr_r = '0; ovr_if.ovr_g = '0; ovr_if.ovr_b = '0;
        cyc(2);
        chk("rst_red", int'(red), 0);
        chk("rst_green", int'(green), 0);
        chk("rst_blue", int'(blue), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_ovr_ready", int'(ovr_if.ovr_ready), 1);
        chk("rst_period_stb", int'(period_stb), 0);
        chk("rst_state", int'(state), int'(IDLE));

        // T2/T3: full wheel plus wrap back to phase 0
        do_reset();
        start_run();
        for (int j = 0; j < WHEEL; j++) do_period(A_NONE, 0, 0, 0);
        end_run();
        chk("wheel_period_count", meas_q.size(), WHEEL + 1);
        for (int j = 0; j <= WHEEL && j < meas_q.size() && j < ph_q.size(); j++) begin
            chk($sformatf("wheel_tab_duty[%0d]", j), int'(meas_q[j]),
                int'(pack3(hue_tab[j % WHEEL].r, hue_tab[j % WHEEL].g, hue_tab[j % WHEEL].b)));
            chk($sformatf("wheel_tab_phase[%0d]", j), ph_q[j], hue_tab[j % WHEEL].ph);
        end
        check_queues("wheel");

        // T4: overrides with clamping, first one at p2/ramp=5
        do_reset();
        start_run();
        for (int j = 0; j < 7; j++) do_period(A_NONE, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_period(A_ACCEPT, ovr_tab[i].in_r, ovr_tab[i].in_g, ovr_tab[i].in_b);
            do_period(A_RELEASE, 0, 0, 0);
        end
        end_run();
        if (meas_q.size() >= 16) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("ovr_tab[%0d]", i), int'(meas_q[8 + 2 * i]),
                    int'(pack3(ovr_tab[i].ex_r, ovr_tab[i].ex_g, ovr_tab[i].ex_b)));
            chk("ovr_resume_p2", int'(meas_q[9]), int'(pack3(0, 10, 10)));
        end else begin
            chk("ovr_period_count", meas_q.size(), 16);
        end
        check_queues("ovr");

        // T5: run dropped mid-period, then resumed from frozen phase/ramp
        do_reset();
        start_run();
        for (int j = 0; j < 4; j++) do_period(A_NONE, 0, 0, 0);
        cyc(4);
        run = 1'b0;
        cyc(2);
        chk("pause_red", int'(red), 0);
        chk("pause_green", int'(green), 0);
        chk("pause_blue", int'(blue), 0);
        chk("pause_state", int'(state), int'(IDLE));
        chk("pause_phase", int'(phase), 1);
        cyc(5);
        chk("pause_phase_held", int'(phase), 1);
        chk("pause_no_stb", int'(period_stb), 0);
        chk("pause_green_held", int'(green), 0);
        void'(exp_q.pop_back());
        check_queues("pause_pre");
        start_run();
        do_period(A_NONE, 0, 0, 0);
        do_period(A_NONE, 0, 0, 0);
        end_run();
        if (meas_q.size() > 0) chk("pause_resume_duty", int'(meas_q[0]), int'(pack3(5, 10, 0)));
        check_queues("pause_resume");

        // T6: asynchronous reset during HOLD
        do_reset();
        start_run();
        for (int j = 0; j < 4; j++) do_period(A_NONE, 0, 0, 0);
        do_period(A_ACCEPT, 10, 10, 10);
        cyc(3);
        chk("hold_red_high", int'(red), 1);
        chk("hold_state", int'(state), int'(HOLD));
        #2 rst_n = 1'b0;
        #1;
        chk("async_red", int'(red), 0);
        chk("async_green", int'(green), 0);
        chk("async_blue", int'(blue), 0);
        chk("async_stb", int'(period_stb), 0);
        chk("async_ovr_ready", int'(ovr_if.ovr_ready), 1);
        chk("async_phase", int'(phase), 0);
        chk("async_state", int'(state), int'(IDLE));
        run = 1'b0;
        #2 rst_n = 1'b1;
        cyc(2);
        chk("post_rst_state", int'(state), int'(IDLE));
        chk("post_rst_ovr_ready", int'(ovr_if.ovr_ready), 1);
        clear_queues();

        // Randomized override/release traffic against the model
        do_reset();
        start_run();
        for (int j = 0; j < 40; j++) begin
            int a;
            a = $urandom_range(0, 3);
            if (a == 2)
                do_period(A_ACCEPT, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            else if (a == 3)
                do_period(A_RELEASE, 0, 0, 0);
            else
                do_period(A_NONE, 0, 0, 0);
        end
        do_period(A_RELEASE, 0, 0, 0);
        end_run();
        check_queues("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
